// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The optional display path is enabled with the DIV_SEG_EN macro.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIV_DW_N = 16;
   localparam int DIV_DW_D = 8;

   localparam logic [DIV_DW_N-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/seq_divider_hex_to_seg.sv
// Combinational 4-bit to 7-segment decoder, active-low {g,f,e,d,c,b,a}.
// Used only when the divider is built with DIV_SEG_EN.
module hex_to_seg (
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = 7'h7F;
      case (i_nib)
         4'h0: o_seg = 7'h40;
         4'h1: o_seg = 7'h79;
         4'h2: o_seg = 7'h24;
         4'h3: o_seg = 7'h30;
         4'h4: o_seg = 7'h19;
         4'h5: o_seg = 7'h12;
         4'h6: o_seg = 7'h02;
         4'h7: o_seg = 7'h78;
         4'h8: o_seg = 7'h00;
         4'h9: o_seg = 7'h10;
         4'hA: o_seg = 7'h08;
         4'hB: o_seg = 7'h03;
         4'hC: o_seg = 7'h46;
         4'hD: o_seg = 7'h21;
         4'hE: o_seg = 7'h06;
         default: o_seg = 7'h0E;
      endcase
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, with start/locked/done_flag handshake.
// Define DIV_SEG_EN to add the multiplexed 6-digit hex display of the last result.
module seq_divider
   import divider_pkg::*;
#(
   parameter int DW_N = DIV_DW_N,
   parameter int DW_D = DIV_DW_D
`ifdef DIV_SEG_EN
   , parameter int SCAN_DIV = 1000
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [DW_N-1:0] dividend,
   input  logic [DW_D-1:0] divisor,
   output logic            locked,
   output logic [DW_N-1:0] quotient,
   output logic [DW_D-1:0] remainder,
   output logic            div_zero,
   output logic            done_flag
`ifdef DIV_SEG_EN
   , output logic [7:0]    seg_position
   , output logic [7:0]    seg_data
`endif
);

   localparam int CW = $clog2(DW_N);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [DW_D-1:0] r_dvs;
   logic [DW_D-1:0] r_rem;
   logic [DW_N-1:0] r_q;
   logic            r_zero;

   logic [DW_D:0]   w_r;
   logic            w_ge;
   logic [DW_D-1:0] w_diff;
   logic [DW_D-1:0] w_rem_nxt;
   logic [DW_N-1:0] w_q_nxt;

   // The partial remainder is always below the divisor, so the low DW_D bits of the difference are exact.
   assign w_r       = {r_rem, r_q[DW_N-1]};
   assign w_ge      = (w_r >= {1'b0, r_dvs});
   assign w_diff    = w_r[DW_D-1:0] - r_dvs;
   assign w_rem_nxt = w_ge ? w_diff : w_r[DW_D-1:0];
   assign w_q_nxt   = {r_q[DW_N-2:0], w_ge};

   always_ff @(posedge clk) begin
      if (r_state == IDLE && start) begin
         r_dvs  <= divisor;
         r_q    <= dividend;
         r_rem  <= '0;
         r_zero <= (divisor == '0);
      end else if (r_state == CALC) begin
         r_q   <= w_q_nxt;
         r_rem <= w_rem_nxt;
      end
   end

   // A zero divisor makes a single pass through CALC so its result lands one cycle after accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         locked    <= 1'b0;
         done_flag <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         done_flag <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cnt   <= (divisor == '0) ? CW'(DW_N - 1) : '0;
                  locked  <= 1'b1;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(DW_N - 1)) begin
                  r_state   <= DONE;
                  done_flag <= 1'b1;
                  if (r_zero) begin
                     quotient  <= DW_N'(DIV_ZERO_Q);
                     remainder <= r_q[DW_D-1:0];
                     div_zero  <= 1'b1;
                  end else begin
                     quotient  <= w_q_nxt;
                     remainder <= w_rem_nxt;
                     div_zero  <= 1'b0;
                  end
               end
            end
            DONE: begin
               locked  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef DIV_SEG_EN
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [SW-1:0] r_scan;
   logic [2:0]    r_digit;
   logic [3:0]    w_nib;
   logic [6:0]    w_seg7;

   always_comb begin
      w_nib = 4'h0;
      case (r_digit)
         3'd0:    w_nib = quotient[3:0];
         3'd1:    w_nib = quotient[7:4];
         3'd2:    w_nib = quotient[11:8];
         3'd3:    w_nib = quotient[15:12];
         3'd4:    w_nib = remainder[3:0];
         3'd5:    w_nib = remainder[7:4];
         default: w_nib = 4'h0;
      endcase
   end

   hex_to_seg u_hex (
      .i_nib (w_nib),
      .o_seg (w_seg7)
   );

   // Position and segment data are registered together so they always refer to the same digit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scan       <= '0;
         r_digit      <= '0;
         seg_position <= 8'hFF;
         seg_data     <= 8'hFF;
      end else begin
         if (r_scan == SW'(SCAN_DIV - 1)) begin
            r_scan  <= '0;
            r_digit <= (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
         end else begin
            r_scan <= r_scan + 1'b1;
         end
         seg_position <= ~(8'h01 << r_digit);
         seg_data     <= {~div_zero, w_seg7};
      end
   end
`endif

endmodule
